fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 35 +++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: word width, opcode field and two-word opcodes.
package fetch_unit_pkg;

    localparam int unsigned WORD  = 16;
    localparam int unsigned OP_HI = 15;
    localparam int unsigned OP_LO = 12;

    localparam logic [3:0] OP_CALL  = 4'hC;
    localparam logic [3:0] OP_JUMP  = 4'hD;
    localparam logic [3:0] OP_JUMPF = 4'hE;

    // One decoded-ready packet handed to the decode stage.
    typedef struct packed {
        logic [WORD-1:0] ir;
        logic [WORD-1:0] imm;
        logic [WORD-1:0] pc;
        logic            two;
    } fetch_pkt_t;

    localparam int unsigned PKT_W = $bits(fetch_pkt_t);

    // W0: expecting a first word; W1: first word held, expecting its extension.
    typedef enum logic {
        StW0,
        StW1
    } fetch_state_e;

    // True when the instruction word carries a 16-bit extension word.
    function automatic logic is_two_word(input logic [WORD-1:0] ir);
        logic [3:0] op;
        op = ir[OP_HI:OP_LO];
        return (op == OP_CALL) || (op == OP_JUMP) || (op == OP_JUMPF);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Packet FIFO between fetch and decode; flush empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [PKT_W-1:0]       push_data,
    input  logic                   pop,
    output logic [PKT_W-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding synchronous imem read, assembles one- and
// two-word instructions into packets and buffers them for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [WORD-1:0] imem_addr,
    input  logic [WORD-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_ir,
    output logic [WORD-1:0] out_imm,
    output logic [WORD-1:0] out_pc,
    output logic            out_two
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [WORD-1:0] fetch_pc_q;
    logic            rd_pending_q;
    logic            rd_ext_q;
    logic [WORD-1:0] rd_addr_q;
    logic [WORD-1:0] held_ir_q;
    logic [WORD-1:0] held_pc_q;

    logic            ret_first;
    logic            ret_ext;
    logic            ret_two;
    logic            rd_issue;
    logic            rd_issue_ext;
    logic [CNT_W:0]  occupancy;

    logic            fifo_push;
    logic            fifo_pop;
    fetch_pkt_t      push_pkt;
    fetch_pkt_t      head_pkt;
    logic [CNT_W-1:0] fifo_count;

    assign ret_first = rd_pending_q && !rd_ext_q;
    assign ret_ext   = rd_pending_q && rd_ext_q;
    assign ret_two   = ret_first && is_two_word(imem_rdata);

    // Slots already committed: buffered packets, the read in flight, and a held first word.
    // A pop in this cycle is deliberately not credited.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(rd_pending_q)
                     + (CNT_W + 1)'(state_q == StW1);

    // Next state and packet assembly from the returning word.
    always_comb begin
        state_d   = state_q;
        fifo_push = 1'b0;
        push_pkt  = '0;
        if (ret_ext) begin
            fifo_push    = 1'b1;
            push_pkt.ir  = held_ir_q;
            push_pkt.imm = imem_rdata;
            push_pkt.pc  = held_pc_q;
            push_pkt.two = 1'b1;
            state_d      = StW0;
        end else if (ret_first) begin
            if (ret_two) begin
                state_d = StW1;
            end else begin
                fifo_push   = 1'b1;
                push_pkt.ir = imem_rdata;
                push_pkt.pc = rd_addr_q;
            end
        end
        // Redirect discards the returning word and restarts in W0.
        if (reset || redirect) begin
            fifo_push = 1'b0;
            state_d   = StW0;
        end
    end

    // Read issue and address selection; the extension read goes out in the same
    // cycle its first word returns, so only one read is ever outstanding.
    always_comb begin
        imem_addr    = fetch_pc_q;
        rd_issue     = 1'b0;
        rd_issue_ext = 1'b0;
        if (reset) begin
            imem_addr = '0;
        end else if (redirect) begin
            imem_addr = redirect_pc;
            rd_issue  = 1'b1;
        end else if (state_d == StW1) begin
            rd_issue     = 1'b1;
            rd_issue_ext = 1'b1;
        end else if (occupancy < (CNT_W + 1)'(DEPTH)) begin
            rd_issue = 1'b1;
        end
    end

    // PC, FSM state and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StW0;
            fetch_pc_q   <= '0;
            rd_pending_q <= 1'b0;
            rd_ext_q     <= 1'b0;
            rd_addr_q    <= '0;
            held_ir_q    <= '0;
            held_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_issue;
            rd_ext_q     <= rd_issue_ext;
            if (rd_issue) begin
                rd_addr_q  <= imem_addr;
                fetch_pc_q <= imem_addr + WORD'(1);
            end
            if (ret_two && !redirect) begin
                held_ir_q <= imem_rdata;
                held_pc_q <= rd_addr_q;
            end
        end
    end

    assign fifo_pop = out_valid && out_ready && !redirect;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (push_pkt),
        .pop       (fifo_pop),
        .head      (head_pkt),
        .count     (fifo_count)
    );

    // Head fields read as zero whenever nothing is valid.
    assign out_valid = (fifo_count != '0);
    assign out_ir    = out_valid ? head_pkt.ir  : '0;
    assign out_imm   = out_valid ? head_pkt.imm : '0;
    assign out_pc    = out_valid ? head_pkt.pc  : '0;
    assign out_two   = out_valid ? head_pkt.two : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous-read instruction memory model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ir;
    logic [15:0] out_imm;
    logic [15:0] out_pc;
    logic        out_two;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    fetch_unit #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ir      (out_ir),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_two     (out_two)
    );

    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Advance cycle by cycle until a packet is visible or the budget runs out.
    task automatic wait_pkt(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            cyc_begin();
            sample();
            if (out_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; out_ready = 1'b1;
        cyc_begin(); cyc_begin();
        cyc_begin();
        // last reset cycle R, with a redirect that reset must override
        redirect = 1'b1; redirect_pc = 16'h1234;
        sample();
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_addr: got valid=%b addr=%h expected valid=0 addr=0000",
                     out_valid, imem_addr);
        end
        cyc_begin();
        reset = 1'b0; redirect = 1'b0;
        sample();  // R+1
        checks++;
        if ({out_valid, out_ir, out_imm, out_pc, out_two, imem_addr} !== {1'b0, 65'h0}) begin
            errors++;
            $display("FAIL reset_r1: got valid=%b ir=%h imm=%h pc=%h two=%b addr=%h expected all 0",
                     out_valid, out_ir, out_imm, out_pc, out_two, imem_addr);
        end
        cyc_begin(); sample();  // R+2
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 16'h0001}) begin
            errors++;
            $display("FAIL reset_r2: got valid=%b addr=%h expected valid=0 addr=0001",
                     out_valid, imem_addr);
        end
        cyc_begin(); sample();  // R+3
        checks++;
        if ({out_valid, out_ir, out_imm, out_pc, out_two} !== {1'b1, 16'h1123, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_pkt_r3: got v=%b ir=%h imm=%h pc=%h two=%b expected 1 1123 0000 0000 0",
                     out_valid, out_ir, out_imm, out_pc, out_two);
        end
        cyc_begin(); sample();  // R+4
        checks++;
        if ({out_valid, out_ir, out_imm, out_pc, out_two} !== {1'b1, 16'h9205, 16'h0, 16'h1, 1'b0}) begin
            errors++;
            $display("FAIL second_pkt: got v=%b ir=%h imm=%h pc=%h two=%b expected 1 9205 0000 0001 0",
                     out_valid, out_ir, out_imm, out_pc, out_two);
        end
    endtask

    task automatic test_two_word();
        bit got;
        wait_pkt(10, got);
        checks++;
        if (!got || {out_ir, out_imm, out_pc, out_two} !== {16'hD000, 16'h0040, 16'h0002, 1'b1}) begin
            errors++;
            $display("FAIL two_word_pkt: got v=%b ir=%h imm=%h pc=%h two=%b expected D000 0040 0002 1",
                     out_valid, out_ir, out_imm, out_pc, out_two);
        end
        wait_pkt(10, got);
        checks++;
        if (!got || {out_ir, out_imm, out_pc, out_two} !== {16'h1004, 16'h0, 16'h0004, 1'b0}) begin
            errors++;
            $display("FAIL after_two_word: got v=%b ir=%h imm=%h pc=%h two=%b expected 1004 0000 0004 0",
                     out_valid, out_ir, out_imm, out_pc, out_two);
        end
    endtask

    task automatic test_backpressure();
        bit got;
        logic [15:0] exp_pc;
        cyc_begin();
        redirect = 1'b1; redirect_pc = 16'h0100; out_ready = 1'b0;
        sample();  // N
        checks++;
        if (imem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL bp_redirect_addr: got %h expected 0100", imem_addr);
        end
        cyc_begin();
        redirect = 1'b0;
        sample();  // N+1
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_n1_valid: got %b expected 0", out_valid);
        end
        for (int c = 2; c <= 10; c++) begin
            cyc_begin(); sample();
            checks++;
            if ({out_valid, out_ir, out_imm, out_pc, out_two} !== {1'b1, 16'h1100, 16'h0, 16'h0100, 1'b0}) begin
                errors++;
                $display("FAIL bp_head_stable cyc N+%0d: got v=%b ir=%h pc=%h expected 1 1100 0100",
                         c, out_valid, out_ir, out_pc);
            end
        end
        checks++;
        if (imem_addr !== 16'h0102) begin
            errors++;
            $display("FAIL bp_reads_stopped: got addr %h expected 0102", imem_addr);
        end
        // release: the second buffered packet must follow on the very next cycle
        cyc_begin();
        out_ready = 1'b1;
        sample();
        cyc_begin(); sample();
        checks++;
        if ({out_valid, out_ir, out_pc} !== {1'b1, 16'h1101, 16'h0101}) begin
            errors++;
            $display("FAIL bp_second_buffered: got v=%b ir=%h pc=%h expected 1 1101 0101",
                     out_valid, out_ir, out_pc);
        end
        for (int k = 2; k < 5; k++) begin
            exp_pc = 16'h0100 + 16'(k);
            wait_pkt(10, got);
            checks++;
            if (!got || {out_ir, out_pc, out_two} !== {16'h1000 | exp_pc, exp_pc, 1'b0}) begin
                errors++;
                $display("FAIL bp_order k=%0d: got v=%b ir=%h pc=%h expected ir=%h pc=%h",
                         k, out_valid, out_ir, out_pc, 16'h1000 | exp_pc, exp_pc);
            end
        end
    endtask

    task automatic test_redirect_full();
        bit got;
        mem[16'h0040] = 16'h2345;
        cyc_begin();
        redirect = 1'b1; redirect_pc = 16'h0200; out_ready = 1'b0;
        sample();
        cyc_begin();
        redirect = 1'b0;
        sample();
        cyc_begin();
        redirect = 1'b1; redirect_pc = 16'h0040;
        sample();  // N: one packet buffered, 0x201 returning
        checks++;
        if ({out_valid, out_ir, imem_addr} !== {1'b1, 16'h1200, 16'h0040}) begin
            errors++;
            $display("FAIL rf_n: got v=%b ir=%h addr=%h expected 1 1200 0040",
                     out_valid, out_ir, imem_addr);
        end
        cyc_begin();
        redirect = 1'b0; out_ready = 1'b1;
        sample();  // N+1
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rf_flushed: got valid %b expected 0", out_valid);
        end
        cyc_begin(); sample();  // N+2
        checks++;
        if ({out_valid, out_ir, out_imm, out_pc, out_two} !== {1'b1, 16'h2345, 16'h0, 16'h0040, 1'b0}) begin
            errors++;
            $display("FAIL rf_target_n2: got v=%b ir=%h imm=%h pc=%h two=%b expected 1 2345 0000 0040 0",
                     out_valid, out_ir, out_imm, out_pc, out_two);
        end
        wait_pkt(10, got);
        checks++;
        if (!got || {out_ir, out_pc} !== {16'h1041, 16'h0041}) begin
            errors++;
            $display("FAIL rf_next: got v=%b ir=%h pc=%h expected 1041 0041", out_valid, out_ir, out_pc);
        end
    endtask

    task automatic test_wrap();
        bit got;
        mem[16'hFFFF] = 16'hC000;
        mem[16'h0000] = 16'h0010;
        cyc_begin();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        sample();  // N
        cyc_begin();
        redirect = 1'b0;
        sample();  // N+1: extension read wraps to 0
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_ext_addr: got v=%b addr=%h expected 0 0000", out_valid, imem_addr);
        end
        cyc_begin(); sample();  // N+2
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_n2_valid: got %b expected 0", out_valid);
        end
        cyc_begin(); sample();  // N+3
        checks++;
        if ({out_valid, out_ir, out_imm, out_pc, out_two} !== {1'b1, 16'hC000, 16'h0010, 16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL wrap_pkt_n3: got v=%b ir=%h imm=%h pc=%h two=%b expected 1 C000 0010 FFFF 1",
                     out_valid, out_ir, out_imm, out_pc, out_two);
        end
        wait_pkt(10, got);
        checks++;
        if (!got || {out_ir, out_pc, out_two} !== {16'h9205, 16'h0001, 1'b0}) begin
            errors++;
            $display("FAIL wrap_continue: got v=%b ir=%h pc=%h expected 9205 0001", out_valid, out_ir, out_pc);
        end
    endtask

    task automatic test_reset_w1();
        mem[16'h0000] = 16'h1123;
        mem[16'h0301] = 16'hE000;
        cyc_begin();
        redirect = 1'b1; redirect_pc = 16'h0300; out_ready = 1'b0;
        sample();
        cyc_begin();
        redirect = 1'b0;
        sample();
        cyc_begin(); sample();
        cyc_begin();
        reset = 1'b1;
        sample();  // W1 held, one packet buffered
        checks++;
        if ({out_valid, out_ir, imem_addr} !== {1'b1, 16'h1300, 16'h0000}) begin
            errors++;
            $display("FAIL rw1_before: got v=%b ir=%h addr=%h expected 1 1300 0000",
                     out_valid, out_ir, imem_addr);
        end
        cyc_begin();
        reset = 1'b0; out_ready = 1'b1;
        sample();  // R+1
        checks++;
        if ({out_valid, out_ir, out_pc, imem_addr} !== {1'b0, 48'h0}) begin
            errors++;
            $display("FAIL rw1_cleared: got v=%b ir=%h pc=%h addr=%h expected 0 0000 0000 0000",
                     out_valid, out_ir, out_pc, imem_addr);
        end
        cyc_begin(); sample();
        cyc_begin(); sample();  // R+3
        checks++;
        if ({out_valid, out_ir, out_imm, out_pc, out_two} !== {1'b1, 16'h1123, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL rw1_restart: got v=%b ir=%h imm=%h pc=%h two=%b expected 1 1123 0000 0000 0",
                     out_valid, out_ir, out_imm, out_pc, out_two);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 | (16'(i) & 16'h0FFF);
        mem[0] = 16'h1123;
        mem[1] = 16'h9205;
        mem[2] = 16'hD000;
        mem[3] = 16'h0040;
        test_reset();
        test_two_word();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_reset_w1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
